// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source pulses into a pending register, masks with enable,
// and runs a fixed-priority assert/claim/EOI handshake with the CPU over the peripheral bus.
module irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_valid,
    input  logic               bus_write,
    input  logic [18:0]        bus_addr,
    input  logic [18:0]        bus_wdata,
    output logic [18:0]        bus_rdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               cpu_irq,
    output logic [IDW-1:0]     cpu_irq_id,
    input  logic               cpu_irq_ack
);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;
    logic               cpu_irq_q, cpu_irq_d;
    logic [IDW-1:0]     cpu_irq_id_q, cpu_irq_id_d;

    logic               wr_en;
    logic               wr_pend, wr_enab, wr_eoi;
    logic               claim;
    logic [NUM_SRC-1:0] cur_mask;
    logic [NUM_SRC-1:0] avail;

    // Only addr[3:2] and the low NUM_SRC data bits carry meaning.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_addr[18:4], bus_addr[1:0], bus_wdata[18:NUM_SRC]};

    always_comb begin
        wr_en   = bus_valid && bus_write;
        wr_pend = wr_en && (bus_addr[3:2] == 2'b00);
        wr_enab = wr_en && (bus_addr[3:2] == 2'b01);
        wr_eoi  = wr_en && (bus_addr[3:2] == 2'b11);
        claim   = (state_q == ASSERT) && cpu_irq_ack;

        cur_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_id_q == IDW'(i)) cur_mask[i] = 1'b1;
        end

        // Clears first, then sets, so a same-cycle source event always survives.
        pending_d = pending_q;
        if (wr_pend) pending_d = pending_d & ~bus_wdata[NUM_SRC-1:0];
        if (claim)   pending_d = pending_d & ~cur_mask;
        pending_d = pending_d | irq_src;

        enable_d = wr_enab ? bus_wdata[NUM_SRC-1:0] : enable_q;

        avail    = pending_q & enable_q;
        state_d  = state_q;
        cur_id_d = cur_id_q;
        unique case (state_q)
            IDLE: begin
                if (|avail) begin
                    for (int i = NUM_SRC - 1; i >= 0; i--) begin
                        if (avail[i]) cur_id_d = IDW'(i);
                    end
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (cpu_irq_ack) begin
                    state_d = SERVICE;
                end else if ((pending_d & enable_d & cur_mask) == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_irq_d    = (state_d == ASSERT);
        cpu_irq_id_d = cur_id_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            enable_q     <= '0;
            cur_id_q     <= '0;
            cpu_irq_q    <= 1'b0;
            cpu_irq_id_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            cur_id_q     <= cur_id_d;
            cpu_irq_q    <= cpu_irq_d;
            cpu_irq_id_q <= cpu_irq_id_d;
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_valid && !bus_write) begin
            unique case (bus_addr[3:2])
                2'b00: bus_rdata[NUM_SRC-1:0] = pending_q;
                2'b01: bus_rdata[NUM_SRC-1:0] = enable_q;
                2'b10: begin
                    bus_rdata[IDW-1:0] = cur_id_q;
                    bus_rdata[17]      = (state_q == ASSERT);
                    bus_rdata[18]      = (state_q == SERVICE);
                end
                default: bus_rdata = '0;
            endcase
        end
    end

    assign cpu_irq    = cpu_irq_q;
    assign cpu_irq_id = cpu_irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, priority, claim/EOI handshake,
// withdraw, set-beats-clear and mid-operation reset, with hand-computed expectations.
module tb_irq_ctrl;

    localparam int NUM_SRC = 4;
    localparam int IDW     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               bus_valid;
    logic               bus_write;
    logic [18:0]        bus_addr;
    logic [18:0]        bus_wdata;
    logic [18:0]        bus_rdata;
    logic [NUM_SRC-1:0] irq_src;
    logic               cpu_irq;
    logic [IDW-1:0]     cpu_irq_id;
    logic               cpu_irq_ack;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] A_PEND = 2'b00;
    localparam logic [1:0] A_ENAB = 2'b01;
    localparam logic [1:0] A_STAT = 2'b10;
    localparam logic [1:0] A_EOI  = 2'b11;

    irq_ctrl #(.NUM_SRC(NUM_SRC), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_valid   (bus_valid),
        .bus_write   (bus_write),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .irq_src     (irq_src),
        .cpu_irq     (cpu_irq),
        .cpu_irq_id  (cpu_irq_id),
        .cpu_irq_ack (cpu_irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
    endtask

    task automatic wr_set(input logic [1:0] a, input logic [18:0] d);
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_addr  = {15'd0, a, 2'b00};
        bus_wdata = d;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [18:0] d);
        wr_set(a, d);
        tick();
        bus_idle();
    endtask

    task automatic bus_rd(input string tag, input logic [1:0] a, input logic [18:0] exp);
        bus_valid = 1'b1;
        bus_write = 1'b0;
        bus_addr  = {15'd0, a, 2'b00};
        #1;
        chk(tag, bus_rdata, exp);
        bus_idle();
    endtask

    task automatic irq_chk(input string tag, input logic exp_irq, input logic [IDW-1:0] exp_id);
        chk({tag, "_irq"}, {18'd0, cpu_irq}, {18'd0, exp_irq});
        chk({tag, "_id"}, {17'd0, cpu_irq_id}, {17'd0, exp_id});
    endtask

    initial begin
        rst         = 1'b1;
        irq_src     = '0;
        cpu_irq_ack = 1'b0;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state and basic register access
        irq_chk("rst", 1'b0, 2'd0);
        bus_rd("rst_pend", A_PEND, 19'h0);
        bus_rd("rst_enab", A_ENAB, 19'h0);
        bus_rd("rst_stat", A_STAT, 19'h0);
        bus_rd("rst_eoi",  A_EOI,  19'h0);
        bus_wr(A_ENAB, 19'h7FFFF);
        bus_rd("enab_f",   A_ENAB, 19'hF);
        bus_rd("pend_0",   A_PEND, 19'h0);

        // Single source, full handshake
        bus_wr(A_ENAB, 19'h1);
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        irq_chk("s0_n", 1'b0, 2'd0);
        bus_rd("s0_pend", A_PEND, 19'h1);
        tick();
        irq_chk("s0_assert", 1'b1, 2'd0);
        bus_rd("s0_stat_a", A_STAT, 19'h20000);
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        irq_chk("s0_ack", 1'b0, 2'd0);
        bus_rd("s0_pend_ack", A_PEND, 19'h0);
        bus_rd("s0_stat_s", A_STAT, 19'h40000);
        bus_wr(A_EOI, 19'h0);
        bus_rd("s0_stat_eoi", A_STAT, 19'h0);
        tick();
        irq_chk("s0_idle", 1'b0, 2'd0);

        // Two sources same cycle: lowest index first, then the other after EOI
        bus_wr(A_ENAB, 19'hF);
        irq_src = 4'b1010;
        tick();
        irq_src = '0;
        tick();
        irq_chk("p_first", 1'b1, 2'd1);
        bus_rd("p_pend_a", A_PEND, 19'hA);
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        irq_chk("p_ack1", 1'b0, 2'd1);
        bus_rd("p_pend_b", A_PEND, 19'h8);
        tick();
        irq_chk("p_no_nest", 1'b0, 2'd1);
        bus_wr(A_EOI, 19'h0);
        irq_chk("p_eoi_gap", 1'b0, 2'd1);
        tick();
        irq_chk("p_second", 1'b1, 2'd3);
        bus_rd("p_pend_c", A_PEND, 19'h8);
        bus_rd("p_stat_3", A_STAT, 19'h20003);
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        bus_rd("p_pend_d", A_PEND, 19'h0);
        bus_wr(A_EOI, 19'h0);
        bus_rd("p_stat_end", A_STAT, 19'h3);

        // Masked source, late enable, withdraw by W1C
        bus_wr(A_ENAB, 19'h0);
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        tick();
        tick();
        bus_rd("m_pend", A_PEND, 19'h4);
        irq_chk("m_masked", 1'b0, 2'd3);
        bus_wr(A_ENAB, 19'h4);
        irq_chk("m_en_w", 1'b0, 2'd3);
        tick();
        irq_chk("m_assert", 1'b1, 2'd2);
        bus_wr(A_PEND, 19'h4);
        irq_chk("m_withdraw", 1'b0, 2'd2);
        bus_rd("m_stat", A_STAT, 19'h2);
        bus_rd("m_pend_clr", A_PEND, 19'h0);
        tick();
        irq_chk("m_stay", 1'b0, 2'd2);

        // Set beats same-cycle W1C while in SERVICE; re-assert after EOI
        bus_wr(A_ENAB, 19'h1);
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        tick();
        irq_chk("sw_assert", 1'b1, 2'd0);
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        bus_rd("sw_pend0", A_PEND, 19'h0);
        wr_set(A_PEND, 19'h1);
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        bus_idle();
        bus_rd("sw_pend1", A_PEND, 19'h1);
        bus_rd("sw_stat_s", A_STAT, 19'h40000);
        irq_chk("sw_svc", 1'b0, 2'd0);
        bus_wr(A_EOI, 19'h0);
        irq_chk("sw_eoi", 1'b0, 2'd0);
        tick();
        irq_chk("sw_reassert", 1'b1, 2'd0);

        // Reset while asserted, then a stray ack
        rst = 1'b1;
        tick();
        rst = 1'b0;
        irq_chk("r_rst", 1'b0, 2'd0);
        bus_rd("r_pend", A_PEND, 19'h0);
        bus_rd("r_enab", A_ENAB, 19'h0);
        bus_rd("r_stat", A_STAT, 19'h0);
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        tick();
        irq_chk("r_stray", 1'b0, 2'd0);
        bus_rd("r_stat2", A_STAT, 19'h0);
        bus_rd("r_pend2", A_PEND, 19'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
